// File: rtl/mario_motion_pkg.sv
// Shared definitions for the player-motion engine: state encoding and sizing helpers.
package mario_motion_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    GROUND = 2'd0,
    JUMP   = 2'd1,
    FALL   = 2'd2,
    DEAD   = 2'd3
  } motion_state_e;

  // Jump counter width, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_step.sv
// Saturating single-step add/subtract with clamps; one extra bit so nothing wraps.
module sat_step #(
  parameter int unsigned W    = 8,
  parameter int unsigned STEP = 1,
  parameter int unsigned LO   = 0,
  parameter int unsigned HI   = 255
) (
  input  logic [W-1:0] val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] res_c,
  output logic         clamp_c
);

  localparam int unsigned EW = W + 1;

  logic [EW-1:0] ext;
  logic [EW-1:0] sum;
  logic [EW-1:0] diff;
  logic [EW-1:0] dn_bound;

  always_comb begin
    ext      = EW'(val);
    sum      = ext + EW'(STEP);
    diff     = ext - EW'(STEP);
    dn_bound = EW'(LO) + EW'(STEP);
    res_c    = val;
    clamp_c  = 1'b0;
    if (inc) begin
      clamp_c = (sum > EW'(HI));
      res_c   = clamp_c ? W'(HI) : W'(sum);
    end else if (dec) begin
      // val - STEP < LO, evaluated without forming a negative value
      clamp_c = (ext < dn_bound);
      res_c   = clamp_c ? W'(LO) : W'(diff);
    end
  end

endmodule

// File: rtl/mario_motion.sv
// Player-motion engine: sprite position plus ground/jump/fall/dead state, one step per frame tick.
module mario_motion
  import mario_motion_pkg::*;
#(
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 8,
  parameter int unsigned X_MIN      = 1,
  parameter int unsigned X_MAX      = 147,
  parameter int unsigned Y_MIN      = 0,
  parameter int unsigned Y_DEAD     = 104,
  parameter int unsigned X_INIT     = 4,
  parameter int unsigned Y_INIT     = 89,
  parameter int unsigned SPEED_X    = 1,
  parameter int unsigned SPEED_Y    = 1,
  parameter int unsigned JUMP_TICKS = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tick,
  input  logic               load,
  input  logic [X_W-1:0]     load_x,
  input  logic [Y_W-1:0]     load_y,
  input  logic               left,
  input  logic               right,
  input  logic               jump,
  input  logic               solid_left,
  input  logic               solid_right,
  input  logic               solid_above,
  input  logic               solid_below,
  output logic [X_W-1:0]     pos_x,
  output logic [Y_W-1:0]     pos_y,
  output logic [STATE_W-1:0] state,
  output logic               dead,
  output logic               moved
);

  localparam int unsigned CNT_W = cnt_width(JUMP_TICKS);
  localparam int unsigned Y_TOP = (32'd1 << Y_W) - 32'd1;

  motion_state_e  st_q, st_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic           jp_q, jp_n;
  logic [X_W-1:0] x_n, x_step;
  logic [Y_W-1:0] y_n, y_step;
  logic           dead_n, moved_n;
  logic           x_inc, x_dec, y_inc, y_dec;
  logic           x_clamp, y_clamp;
  logic           unused_x_clamp;

  assign x_inc = right & ~left & ~solid_right;
  assign x_dec = left & ~right & ~solid_left;
  assign y_inc = (st_q == FALL) & ~solid_below;
  assign y_dec = (st_q == JUMP);
  assign unused_x_clamp = x_clamp;

  sat_step #(.W(X_W), .STEP(SPEED_X), .LO(X_MIN), .HI(X_MAX)) u_step_x (
    .val(pos_x), .inc(x_inc), .dec(x_dec), .res_c(x_step), .clamp_c(x_clamp)
  );

  sat_step #(.W(Y_W), .STEP(SPEED_Y), .LO(Y_MIN), .HI(Y_TOP)) u_step_y (
    .val(pos_y), .inc(y_inc), .dec(y_dec), .res_c(y_step), .clamp_c(y_clamp)
  );

  // Next-state and next-position logic
  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    jp_n   = jp_q;
    x_n    = pos_x;
    y_n    = pos_y;
    dead_n = dead;
    if (load) begin
      x_n    = load_x;
      y_n    = load_y;
      st_n   = FALL;
      cnt_n  = '0;
      dead_n = 1'b0;
    end else if (tick && st_q != DEAD) begin
      jp_n = jump;
      x_n  = x_step;
      case (st_q)
        GROUND: begin
          if (jump && !jp_q && !solid_above) begin
            st_n  = JUMP;
            cnt_n = '0;
          end else if (!solid_below) begin
            st_n = FALL;
          end
        end
        JUMP: begin
          if (solid_above || y_clamp) begin
            st_n = FALL;
          end else begin
            // the ascent at the last counter value still moves, giving JUMP_TICKS steps
            y_n   = y_step;
            cnt_n = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(JUMP_TICKS - 1)) st_n = FALL;
          end
        end
        FALL: begin
          if (solid_below) begin
            st_n = GROUND;
          end else begin
            y_n = y_step;
            if (y_step >= Y_W'(Y_DEAD)) begin
              st_n   = DEAD;
              dead_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    moved_n = (x_n != pos_x) || (y_n != pos_y);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x <= X_W'(X_INIT);
      pos_y <= Y_W'(Y_INIT);
      st_q  <= FALL;
      cnt_q <= '0;
      jp_q  <= 1'b0;
      dead  <= 1'b0;
      moved <= 1'b0;
    end else begin
      pos_x <= x_n;
      pos_y <= y_n;
      st_q  <= st_n;
      cnt_q <= cnt_n;
      jp_q  <= jp_n;
      dead  <= dead_n;
      moved <= moved_n;
    end
  end

  assign state = st_q;

endmodule
